// File: rtl/idct_inv_pkg.sv
// Shared constants, cosine table, FSM states and output rounding for the
// 16-point inverse DCT.
package idct_inv_pkg;

    localparam int DW = 20;
    localparam int CW = 16;
    localparam int AW = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // round(0.3535534 * cos(pi*j/32) * 2^15), j = 0..16
    localparam logic signed [CW-1:0] COS_TAB [0:16] = '{
        16'sd11585, 16'sd11529, 16'sd11363, 16'sd11086,
        16'sd10703, 16'sd10217, 16'sd9633,  16'sd8956,
        16'sd8192,  16'sd7350,  16'sd6436,  16'sd5461,
        16'sd4433,  16'sd3363,  16'sd2260,  16'sd1136,
        16'sd0
    };

    localparam logic signed [AW-1:0] SAT_HI = AW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);

    // Q13.27 accumulator to Q8.12 sample: round half up, then clamp.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] r;
        r = (acc + AW'(16384)) >>> 15;
        if (r > SAT_HI)
            r = SAT_HI;
        else if (r < SAT_LO)
            r = SAT_LO;
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/idct_cos_rom.sv
// Folded cosine coefficient for output index n and frequency k; the DC term
// is handled outside, so k = 0 yields zero.
module idct_cos_rom
    import idct_inv_pkg::*;
(
    input  logic [3:0]           n,
    input  logic [3:0]           k,
    output logic signed [CW-1:0] coef
);

    logic [5:0] m;
    logic [4:0] idx;
    logic       neg;

    always_comb begin
        // 6-bit product wraps naturally, giving ((2n+1)k) mod 64
        m   = {1'b0, n, 1'b1} * {2'b00, k};
        neg = 1'b0;
        if (m <= 6'd16) begin
            idx = m[4:0];
        end else if (m <= 6'd32) begin
            idx = 5'(6'd32 - m);
            neg = 1'b1;
        end else if (m <= 6'd48) begin
            idx = m[4:0];
            neg = 1'b1;
        end else begin
            idx = 5'(6'd0 - m);
        end
        coef = neg ? -COS_TAB[idx] : COS_TAB[idx];
        if (k == 4'd0)
            coef = '0;
    end

endmodule

// File: rtl/idct_cordic_inv.sv
// 16-point inverse DCT (DCT-III) on Q8.12 samples using one time-multiplexed
// multiply-accumulate: 256 cycles per block, valid/ready on both sides.
module idct_cordic_inv
    import idct_inv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] y0,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] y2,
    input  logic signed [DW-1:0] y3,
    input  logic signed [DW-1:0] y4,
    input  logic signed [DW-1:0] y5,
    input  logic signed [DW-1:0] y6,
    input  logic signed [DW-1:0] y7,
    input  logic signed [DW-1:0] y8,
    input  logic signed [DW-1:0] y9,
    input  logic signed [DW-1:0] y10,
    input  logic signed [DW-1:0] y11,
    input  logic signed [DW-1:0] y12,
    input  logic signed [DW-1:0] y13,
    input  logic signed [DW-1:0] y14,
    input  logic signed [DW-1:0] y15,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] x4,
    output logic signed [DW-1:0] x5,
    output logic signed [DW-1:0] x6,
    output logic signed [DW-1:0] x7,
    output logic signed [DW-1:0] x8,
    output logic signed [DW-1:0] x9,
    output logic signed [DW-1:0] x10,
    output logic signed [DW-1:0] x11,
    output logic signed [DW-1:0] x12,
    output logic signed [DW-1:0] x13,
    output logic signed [DW-1:0] x14,
    output logic signed [DW-1:0] x15
);

    state_t                      state;
    logic [3:0]                  n;
    logic [3:0]                  k;
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        acc_next;
    logic signed [AW-1:0]        term;
    logic signed [DW+CW-1:0]     prod;
    logic signed [CW-1:0]        coef;
    logic signed [DW-1:0]        y_in  [16];
    logic signed [DW-1:0]        y_reg [16];
    logic signed [DW-1:0]        x_reg [16];

    assign y_in = '{y0, y1, y2, y3, y4, y5, y6, y7,
                    y8, y9, y10, y11, y12, y13, y14, y15};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    idct_cos_rom u_cos_rom (
        .n    (n),
        .k    (k),
        .coef (coef)
    );

    always_comb begin
        prod = 36'(y_reg[k]) * 36'(coef);
        if (k == 4'd0)
            term = AW'(y_reg[0]) <<< 13;
        else
            term = AW'(prod);
        acc_next = acc + term;
    end

    // Coefficient file carries no reset: it is only read after a fresh accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid)
            y_reg <= y_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            n     <= '0;
            k     <= '0;
            acc   <= '0;
            for (int i = 0; i < 16; i++)
                x_reg[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    k <= k + 4'd1;
                    if (k == 4'd15) begin
                        x_reg[n] <= round_sat(acc_next);
                        acc      <= '0;
                        n        <= n + 4'd1;
                        if (n == 4'd15)
                            state <= DONE;
                    end else begin
                        acc <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign x0  = x_reg[0];
    assign x1  = x_reg[1];
    assign x2  = x_reg[2];
    assign x3  = x_reg[3];
    assign x4  = x_reg[4];
    assign x5  = x_reg[5];
    assign x6  = x_reg[6];
    assign x7  = x_reg[7];
    assign x8  = x_reg[8];
    assign x9  = x_reg[9];
    assign x10 = x_reg[10];
    assign x11 = x_reg[11];
    assign x12 = x_reg[12];
    assign x13 = x_reg[13];
    assign x14 = x_reg[14];
    assign x15 = x_reg[15];

endmodule

// File: tb/tb_idct_cordic_inv.sv
// Directed bench for idct_cordic_inv: DC, single AC, saturation, backpressure,
// mid-block reset, latency and back-to-back blocks.
module tb_idct_cordic_inv;

    localparam int TT [17] = '{11585, 11529, 11363, 11086, 10703, 10217, 9633, 8956,
                               8192, 7350, 6436, 5461, 4433, 3363, 2260, 1136, 0};

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] yp   [16];
    logic signed [19:0] xo   [16];
    logic signed [19:0] blk  [16];
    logic signed [19:0] snap [16];
    int                 n_assert = 0;
    int                 n_fail   = 0;
    int                 cyc;

    always #5 clk = ~clk;

    idct_cordic_inv dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y0(yp[0]),   .y1(yp[1]),   .y2(yp[2]),   .y3(yp[3]),
        .y4(yp[4]),   .y5(yp[5]),   .y6(yp[6]),   .y7(yp[7]),
        .y8(yp[8]),   .y9(yp[9]),   .y10(yp[10]), .y11(yp[11]),
        .y12(yp[12]), .y13(yp[13]), .y14(yp[14]), .y15(yp[15]),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(xo[0]),   .x1(xo[1]),   .x2(xo[2]),   .x3(xo[3]),
        .x4(xo[4]),   .x5(xo[5]),   .x6(xo[6]),   .x7(xo[7]),
        .x8(xo[8]),   .x9(xo[9]),   .x10(xo[10]), .x11(xo[11]),
        .x12(xo[12]), .x13(xo[13]), .x14(xo[14]), .x15(xo[15])
    );

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference straight from x[n] = sum_k y[k]*c(n,k), folded table, round, clamp
    function automatic logic signed [19:0] model_x(input int n);
        longint acc;
        longint r;
        int     m;
        int     c;
        acc = longint'(blk[0]) * 8192;
        for (int k = 1; k < 16; k++) begin
            m = ((2 * n + 1) * k) % 64;
            if (m <= 16)      c = TT[m];
            else if (m <= 32) c = -TT[32 - m];
            else if (m <= 48) c = -TT[m - 32];
            else              c = TT[64 - m];
            acc += longint'(blk[k]) * c;
        end
        r = (acc + 16384) >>> 15;
        if (r > 524287)       r = 524287;
        else if (r < -524288) r = -524288;
        return r[19:0];
    endfunction

    task automatic apply_block();
        @(negedge clk);
        for (int i = 0; i < 16; i++) yp[i] = blk[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (c < 400) begin
            @(posedge clk);
            c++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic check_model(input string pfx);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_x%0d", pfx, i), xo[i], model_x(i));
    endtask

    task automatic check_const(input string pfx, input logic [19:0] v);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_x%0d", pfx, i), xo[i], v);
    endtask

    task automatic handshake(input string pfx);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({pfx, "_hs_out_valid"}, 20'(out_valid), 20'd0);
        check({pfx, "_hs_in_ready"},  20'(in_ready),  20'd1);
    endtask

    initial begin
        int s;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            yp[i]  = '0;
            blk[i] = '0;
        end
        #12;
        check("rst_in_ready",  20'(in_ready),  20'd1);
        check("rst_out_valid", 20'(out_valid), 20'd0);
        check_const("rst", 20'h00000);
        @(negedge clk);
        rst = 1'b1;

        // DC only: 4.0 in y0 gives 1.0 everywhere
        blk[0] = 20'h04000;
        apply_block();
        wait_done(cyc);
        check("dc_latency", 20'(cyc), 20'd256);
        check_const("dc", 20'h01000);
        handshake("dc");

        // Single AC term, then hold the result under backpressure
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[1] = 20'h01000;
        apply_block();
        wait_done(cyc);
        check("ac_latency", 20'(cyc), 20'd256);
        check("ac_x0",  xo[0],  20'h005A1);
        check("ac_x15", xo[15], 20'hFFA5F);
        check_model("ac");
        for (int i = 0; i < 8; i++) begin
            s = int'(xo[i]) + int'(xo[15 - i]);
            check($sformatf("ac_sym%0d", i), 20'(s >= -1 && s <= 1), 20'd1);
        end
        for (int i = 0; i < 16; i++) snap[i] = xo[i];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                for (int i = 0; i < 16; i++) yp[i] = 20'h7FFFF;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("bp_in_ready%0d", c),  20'(in_ready),  20'd0);
            check($sformatf("bp_out_valid%0d", c), 20'(out_valid), 20'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++)
            check($sformatf("bp_hold_x%0d", i), xo[i], snap[i]);
        handshake("bp");

        // Saturation: all coefficients at full scale
        for (int i = 0; i < 16; i++) blk[i] = 20'h7FFFF;
        apply_block();
        wait_done(cyc);
        check("sat_latency", 20'(cyc), 20'd256);
        check("sat_x0", xo[0], 20'h7FFFF);
        check_model("sat");
        handshake("sat");

        // Reset 100 cycles into a block aborts it
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 20'h04000;
        blk[3] = 20'h00800;
        apply_block();
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_out_valid", 20'(out_valid), 20'd0);
        check("mrst_in_ready",  20'(in_ready),  20'd1);
        check_const("mrst", 20'h00000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_rel_in_ready", 20'(in_ready), 20'd1);
        blk[3] = '0;
        apply_block();
        wait_done(cyc);
        check("mrst_dc_latency", 20'(cyc), 20'd256);
        check_const("mrst_dc", 20'h01000);
        handshake("mrst");

        // Back-to-back blocks: next accept one edge after the output handshake
        for (int i = 0; i < 16; i++) blk[i] = 20'(i * 3000 - 20000);
        apply_block();
        wait_done(cyc);
        check("b2b_a_latency", 20'(cyc), 20'd256);
        check_model("b2b_a");
        for (int i = 0; i < 16; i++) blk[i] = 20'(((i % 3) - 1) * 32768 + i * 17);
        @(negedge clk);
        for (int i = 0; i < 16; i++) yp[i] = blk[i];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_d_out_valid", 20'(out_valid), 20'd0);
        check("b2b_d_in_ready",  20'(in_ready),  20'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accept_in_ready", 20'(in_ready), 20'd0);
        wait_done(cyc);
        check("b2b_b_latency", 20'(cyc), 20'd256);
        check_model("b2b_b");
        handshake("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
